// File: rtl/mod_xbee_rx.sv
// Memory-mapped 8N1 UART receiver with a circular receive FIFO and a polled STATUS/DATA register pair.
// Optional level interrupt enabled by `define MOD_XBEE_RX_INT_EN; the `int` line is named intr (int is reserved).
module mod_xbee_rx #(
   parameter int unsigned BAUD_DIV   = 434,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de,
   input  logic [31:0] daddr,
   input  logic [1:0]  drw,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic        rxd,
   output logic        intr
);

   localparam int unsigned BW    = $clog2(BAUD_DIV);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);
   localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                state, state_n;
   logic [BW-1:0]         baud, baud_n;
   logic [2:0]            bitcnt, bitcnt_n;
   logic [7:0]            shreg, shreg_n;
   logic                  sync1, rxs;
   logic                  push_req, frame_err;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [CW-1:0]         count;
   logic                  overrun, ferr;
   logic                  full, ready;
   logic                  wr_stat, pop, clr, push, ovr_set;
   logic [31:0]           status;

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         baud   <= '0;
         bitcnt <= '0;
         shreg  <= '0;
      end else begin
         state  <= state_n;
         baud   <= baud_n;
         bitcnt <= bitcnt_n;
         shreg  <= shreg_n;
      end
   end

   // Frame deserialiser: start verified at mid-bit, then every full bit period
   always_comb begin
      state_n   = state;
      baud_n    = baud + BW'(1);
      bitcnt_n  = bitcnt;
      shreg_n   = shreg;
      push_req  = 1'b0;
      frame_err = 1'b0;
      case (state)
         S_IDLE: begin
            baud_n = '0;
            if (!rxs) state_n = S_START;
         end
         S_START: begin
            if (baud == HALF_M1) begin
               baud_n   = '0;
               bitcnt_n = '0;
               state_n  = rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (baud == FULL_M1) begin
               baud_n   = '0;
               shreg_n  = {rxs, shreg[7:1]};
               bitcnt_n = bitcnt + 3'd1;
               if (bitcnt == 3'd7) state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (baud == FULL_M1) begin
               baud_n  = '0;
               state_n = S_IDLE;
               if (rxs) push_req  = 1'b1;
               else     frame_err = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign full    = (count == CW'(DEPTH));
   assign ready   = (count != '0);
   assign wr_stat = de && (drw == 2'b01) && !daddr[2];
   assign pop     = wr_stat && din[0] && ready;
   assign clr     = wr_stat && din[1];
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign push    = push_req && (!full || pop);
   assign ovr_set = push_req && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + DEPTH_LOG2'(1);
         if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= shreg;
   end

   // Sticky error flags; a new error in the clearing cycle wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         if (clr) begin
            overrun <= 1'b0;
            ferr    <= 1'b0;
         end
         if (ovr_set)   overrun <= 1'b1;
         if (frame_err) ferr    <= 1'b1;
      end
   end

   assign status = (32'(count) << 4) | {28'b0, ferr, overrun, full, ready};

   always_comb begin
      dout = '0;
      if (de && (drw == 2'b10)) begin
         if (daddr[2]) dout = {24'b0, mem[rptr]};
         else          dout = status;
      end
   end

`ifdef MOD_XBEE_RX_INT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) intr <= 1'b0;
      else     intr <= ready;
   end
`else
   assign intr = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{daddr[31:3], daddr[1:0], din[31:2]};

endmodule

// File: tb/tb_mod_xbee_rx.sv
// Self-checking bench for mod_xbee_rx: bus vector table, frame table and scoreboarded FIFO corner sequences.
module tb_mod_xbee_rx;

   localparam int unsigned B = 16;
`ifdef MOD_XBEE_RX_INT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        de = 1'b0;
   logic [31:0] daddr = '0;
   logic [1:0]  drw = 2'b00;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        rxd = 1'b1;
   logic        intr;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   mod_xbee_rx #(.BAUD_DIV(B), .DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .de(de), .daddr(daddr), .drw(drw),
      .din(din), .dout(dout), .rxd(rxd), .intr(intr)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        de;
      logic [1:0]  drw;
      logic        a2;
      logic [31:0] exp;
   } bus_vec_t;

   typedef struct {
      logic [7:0]  b;
      logic        stop;
      logic [31:0] exp_st;
      logic        do_pop;
      logic        do_clr;
      logic [31:0] exp_st2;
   } frame_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%08h exp=%08h", name, act, exp);
      end
   endtask

   task automatic probe(input logic pde, input logic [1:0] pdrw, input logic a2, output logic [31:0] d);
      @(negedge clk);
      de = pde; drw = pdrw; daddr = {29'b0, a2, 2'b00};
      #1 d = dout;
      de = 1'b0; drw = 2'b00;
   endtask

   task automatic rd(input logic a2, output logic [31:0] d);
      probe(1'b1, 2'b10, a2, d);
   endtask

   task automatic wr(input logic a2, input logic [31:0] v);
      @(negedge clk);
      de = 1'b1; drw = 2'b01; daddr = {29'b0, a2, 2'b00}; din = v;
      @(posedge clk);
      #1 de = 1'b0; drw = 2'b00; din = '0;
   endtask

   task automatic check_status(input string name, input logic [31:0] exp);
      logic [31:0] d;
      rd(1'b0, d);
      check(name, d, exp);
   endtask

   // Reads head, compares against the scoreboard, then pops it
   task automatic pop_check();
      logic [31:0] d;
      logic [7:0]  e;
      rd(1'b1, d);
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty act=%08h exp=none", d);
      end else begin
         e = exp_q.pop_front();
         check("data_head", d, {24'b0, e});
      end
      wr(1'b0, 32'h1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(posedge clk);
      #1 rxd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (B) @(posedge clk);
         #1 rxd = b[i];
      end
      repeat (B) @(posedge clk);
      #1 rxd = stop;
      repeat (B) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (8) @(posedge clk);
   endtask

   // Write pop lands on the stop-sample edge of a frame started on the same edge
   task automatic pop_on_stop();
      @(posedge clk);
      repeat (2 + B / 2 + 9 * B - 1) @(posedge clk);
      #1 de = 1'b1; drw = 2'b01; daddr = '0; din = 32'h1;
      @(posedge clk);
      #1 de = 1'b0; drw = 2'b00; din = '0;
   endtask

   task automatic watch_int();
      @(posedge clk);
      repeat (2 + B / 2 + 9 * B) @(posedge clk);
      #1 check("int_at_push", {31'b0, intr}, 32'h0);
      @(posedge clk);
      #1 check("int_after_push", {31'b0, intr}, {31'b0, INT_EN});
   endtask

   bus_vec_t   bvec [6];
   frame_vec_t fvec [6];

   initial begin
      logic [31:0] d;

      bvec[0] = '{1'b1, 2'b10, 1'b0, 32'h0};
      bvec[1] = '{1'b0, 2'b10, 1'b0, 32'h0};
      bvec[2] = '{1'b0, 2'b10, 1'b1, 32'h0};
      bvec[3] = '{1'b1, 2'b01, 1'b0, 32'h0};
      bvec[4] = '{1'b1, 2'b11, 1'b0, 32'h0};
      bvec[5] = '{1'b1, 2'b00, 1'b0, 32'h0};

      fvec[0] = '{8'hA5, 1'b1, 32'h11, 1'b1, 1'b0, 32'h00};
      fvec[1] = '{8'h3C, 1'b0, 32'h08, 1'b0, 1'b1, 32'h00};
      fvec[2] = '{8'hFF, 1'b1, 32'h11, 1'b0, 1'b0, 32'h11};
      fvec[3] = '{8'h00, 1'b1, 32'h21, 1'b1, 1'b0, 32'h11};
      fvec[4] = '{8'h81, 1'b1, 32'h21, 1'b1, 1'b0, 32'h11};
      fvec[5] = '{8'h7E, 1'b0, 32'h19, 1'b1, 1'b1, 32'h00};

      repeat (3) @(posedge clk);
      check("reset_int", {31'b0, intr}, 32'h0);
      @(negedge clk) rst = 1'b0;

      foreach (bvec[i]) begin
         probe(bvec[i].de, bvec[i].drw, bvec[i].a2, d);
         check($sformatf("bus_vec%0d", i), d, bvec[i].exp);
      end

      foreach (fvec[i]) begin
         send_byte(fvec[i].b, fvec[i].stop);
         if (fvec[i].stop) exp_q.push_back(fvec[i].b);
         check_status($sformatf("frame%0d_status", i), fvec[i].exp_st);
         if (fvec[i].do_pop) pop_check();
         if (fvec[i].do_clr) wr(1'b0, 32'h2);
         check_status($sformatf("frame%0d_status2", i), fvec[i].exp_st2);
      end

      // Pop on empty is ignored
      wr(1'b0, 32'h1);
      check_status("pop_empty", 32'h0);

      // Short low glitch on idle line
      @(posedge clk);
      #1 rxd = 1'b0;
      repeat (4) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (40) @(posedge clk);
      check_status("glitch", 32'h0);

      // Overflow: 17 frames, the last one dropped
      for (int i = 0; i < 17; i++) begin
         send_byte(8'(i), 1'b1);
         if (exp_q.size() < 16) exp_q.push_back(8'(i));
      end
      check_status("overflow", 32'h107);
      check("overflow_int", {31'b0, intr}, {31'b0, INT_EN});
      wr(1'b0, 32'h2);
      check_status("overrun_clear", 32'h103);
      for (int i = 0; i < 16; i++) pop_check();
      check_status("drained", 32'h0);
      @(posedge clk);
      #1 check("drained_int", {31'b0, intr}, 32'h0);

      // Full FIFO with pop on the stop-sample edge of frame 17
      for (int i = 0; i < 16; i++) begin
         send_byte(8'h20 + 8'(i), 1'b1);
         exp_q.push_back(8'h20 + 8'(i));
      end
      rd(1'b1, d);
      check("head_before_race", d, 32'h20);
      fork
         send_byte(8'h30, 1'b1);
         pop_on_stop();
      join
      void'(exp_q.pop_front());
      exp_q.push_back(8'h30);
      check_status("race_status", 32'h103);
      for (int i = 0; i < 16; i++) pop_check();
      check_status("race_drained", 32'h0);

      // Interrupt timing, then reset mid-frame
      fork
         send_byte(8'h55, 1'b1);
         watch_int();
      join
      exp_q.push_back(8'h55);
      check_status("pre_reset", 32'h11);
      @(posedge clk);
      #1 rxd = 1'b0;
      repeat (40) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("reset_mid_int", {31'b0, intr}, 32'h0);
      rxd = 1'b1;
      exp_q.delete();
      check_status("reset_mid_status", 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (4) @(posedge clk);
      send_byte(8'h96, 1'b1);
      exp_q.push_back(8'h96);
      check_status("post_reset", 32'h11);
      pop_check();
      check_status("post_reset_drained", 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
